layer_seq: RTL
==============

# layer_seq

Multi-layer sequencer for the tiny_dnn accelerator top. It holds a small table of per-layer descriptors (mode bits plus the full geometry bus) and drives the accelerator's mode strobes and geometry inputs through weight load, bias load and run for each layer in turn. It advances phases by monitoring the src/dst AXI-stream handshakes. It sits between the host register block and the accelerator top, replacing direct software toggling of run/wwrite/bwrite.

## Interface
- N_LAYER, 8: descriptor table depth (power of two, 2..16)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- desc_we  in  1  descriptor write strobe
- desc_addr  in  $clog2(N_LAYER)  descriptor index
- desc_data  in  desc_t (110)  descriptor: wload, backprop, enbias, ss, dd, id, is, ih, iw, ds, od, os, oh, ow, fs, ks, kh, kw
- start  in  1  pulse; begin a sequence
- n_layer  in  5  number of layers to execute (sampled at start)
- abort  in  1  return to IDLE immediately
- src_valid, src_ready, src_last  in  1 each  monitored input-stream handshake
- dst_valid, dst_ready, dst_last  in  1 each  monitored output-stream handshake
- run, wwrite, bwrite, backprop, enbias  out  1 each  accelerator mode outputs
- ss[11:0], dd[3:0], id[3:0], is[9:0], ih[4:0], iw[4:0], ds[11:0], od[3:0], os[9:0], oh[4:0], ow[4:0], fs[9:0], ks[9:0], kh[4:0], kw[4:0]  out  geometry for the current layer
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at sequence completion
- layer_idx  out  4  index of the current layer

## Operation
- States: IDLE, FETCH, WLOAD, BLOAD, RUN, GAP.
- IDLE: on start with busy=0, set idx=0 and latch n_eff=min(n_layer, N_LAYER).
  - If n_eff=0, pulse done next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH (1 cycle): read descriptor[idx] and register all fields into output registers. Next state is WLOAD if wload=1, else BLOAD if enbias=1, else RUN.
- WLOAD: wwrite=1. On src_valid&src_ready&src_last, go to BLOAD if enbias=1, else RUN.
- BLOAD: bwrite=1. On src_valid&src_ready&src_last, go to RUN.
- RUN: run=1. On dst_valid&dst_ready&dst_last, go to GAP.
- GAP (1 cycle): run, wwrite and bwrite are all 0, so the core's ~run reset is seen. If idx==n_eff-1, go to IDLE with done=1; otherwise idx++ and go to FETCH.
- At most one of run, wwrite and bwrite is high in any cycle.
- Geometry, backprop and enbias hold their values from FETCH until the next FETCH. They are not cleared in IDLE.
- Descriptor writes are accepted in any state. A write to the active index does not affect the current layer; it takes effect at the next FETCH of that index.
- abort has priority over every transition: next state is IDLE, strobes drop, and done is not pulsed.
- start while busy is ignored.
- Handshakes in IDLE, FETCH or GAP are ignored. A last beat in WLOAD or BLOAD is ignored unless src_ready=1.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, descriptor table contents undefined.
- Start accepted at cycle 0: FETCH at cycle 1; first strobe and valid geometry at cycle 2.
- Phase exit: a last-beat handshake in cycle t drops the strobe at t+1. The next phase's strobe rises at t+1; there is no bubble between WLOAD and BLOAD or RUN.
- RUN exit: dst last at t gives run=0 at t+1 (GAP) and FETCH or IDLE at t+2.
- done is registered and coincides with the first IDLE cycle.
- Descriptor RAM: synchronous write. A same-cycle write and FETCH read of the same index returns the old data.

## Configuration
- LAYER_SEQ_BIAS_EN defined: BLOAD state present and enbias output driven from the descriptor.
- LAYER_SEQ_BIAS_EN undefined: BLOAD removed, bwrite and enbias tied 0, and the enbias descriptor bit ignored. Descriptor width is unchanged.

## Structure
- layer_seq_pkg holds:
  - desc_t packed struct with field widths matching the geometry ports
  - state_t enum
  - DESC_W=110
- Sub-module layer_desc_ram: N_LAYER×desc_t, one write port, one synchronous read port.

## Test plan
- 1 layer (wload=1, enbias=1, backprop=0, od=4), src last after 16 beats then 8 beats, dst last after 64 beats → wwrite for 16 accepted beats, bwrite for 8, run until dst last, then 1 GAP cycle, then done.
- n_layer=3 with distinct ks (25, 150, 400) → layer_idx steps 0,1,2; ks updates at each FETCH; run low exactly one cycle between layers.
- wload=0, enbias=0 → FETCH goes straight to RUN; wwrite and bwrite never asserted.
- src_last with src_ready=0 in WLOAD → stays in WLOAD; exits the cycle after the ready beat.
- abort during RUN of layer 1 of 3 → next cycle IDLE, run=0, no done; a new start resets to idx 0.
- n_layer=0 → done 1 cycle after start, busy never rises. Macro off → bwrite never asserted with enbias=1.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer: descriptor layout, FSM states, layer-count clamp.
// Optional bias phase is controlled by the LAYER_SEQ_BIAS_EN macro in layer_seq.sv.
package layer_seq_pkg;

    localparam int DESC_W = 110;

    // MSB is a spare bit that pads the record to DESC_W; it is stored but never decoded.
    typedef struct packed {
        logic        spare;
        logic        wload;
        logic        backprop;
        logic        enbias;
        logic [11:0] ss;
        logic [3:0]  dd;
        logic [3:0]  id;
        logic [9:0]  is;
        logic [4:0]  ih;
        logic [4:0]  iw;
        logic [11:0] ds;
        logic [3:0]  od;
        logic [9:0]  os;
        logic [4:0]  oh;
        logic [4:0]  ow;
        logic [9:0]  fs;
        logic [9:0]  ks;
        logic [4:0]  kh;
        logic [4:0]  kw;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WLOAD = 3'd2,
        S_BLOAD = 3'd3,
        S_RUN   = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    function automatic logic [4:0] clamp_layers(input logic [4:0] n, input logic [4:0] cap);
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Descriptor table: one write port and one registered read port.
// On a same-cycle write and read of one entry the read returns the previous contents.
module layer_desc_ram
    import layer_seq_pkg::*;
#(
    parameter int N_LAYER = 8
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(N_LAYER)-1:0] i_waddr,
    input  desc_t                      i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(N_LAYER)-1:0] i_raddr,
    output desc_t                      o_rdata
);

    desc_t r_mem [N_LAYER];
    desc_t r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/layer_seq.sv
// Multi-layer sequencer driving the accelerator's wwrite/bwrite/run strobes and geometry.
// Define LAYER_SEQ_BIAS_EN to include the bias-load phase and the enbias output.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int N_LAYER = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_desc_we,
    input  logic [$clog2(N_LAYER)-1:0] i_desc_addr,
    input  desc_t                      i_desc_data,
    input  logic                       i_start,
    input  logic [4:0]                 i_n_layer,
    input  logic                       i_abort,
    input  logic                       i_src_valid,
    input  logic                       i_src_ready,
    input  logic                       i_src_last,
    input  logic                       i_dst_valid,
    input  logic                       i_dst_ready,
    input  logic                       i_dst_last,
    output logic                       o_run,
    output logic                       o_wwrite,
    output logic                       o_bwrite,
    output logic                       o_backprop,
    output logic                       o_enbias,
    output logic [11:0]                o_ss,
    output logic [3:0]                 o_dd,
    output logic [3:0]                 o_id,
    output logic [9:0]                 o_is,
    output logic [4:0]                 o_ih,
    output logic [4:0]                 o_iw,
    output logic [11:0]                o_ds,
    output logic [3:0]                 o_od,
    output logic [9:0]                 o_os,
    output logic [4:0]                 o_oh,
    output logic [4:0]                 o_ow,
    output logic [9:0]                 o_fs,
    output logic [9:0]                 o_ks,
    output logic [4:0]                 o_kh,
    output logic [4:0]                 o_kw,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [3:0]                 o_layer_idx
);

    localparam int AW = $clog2(N_LAYER);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [4:0]  r_n_eff;
    logic        r_done, w_done_nxt;
    logic        w_rd_en;
    desc_t       r_desc;
    desc_t       w_ram_q;
    desc_t       w_fetch;
    logic [4:0]  w_n_req;
    logic        w_src_end, w_dst_end, w_last_layer;

    layer_desc_ram #(.N_LAYER(N_LAYER)) u_ram (
        .i_clk   (i_clk),
        .i_we    (i_desc_we),
        .i_waddr (i_desc_addr),
        .i_wdata (i_desc_data),
        .i_re    (w_rd_en),
        .i_raddr (w_idx_nxt[AW-1:0]),
        .o_rdata (w_ram_q)
    );

    assign w_n_req      = clamp_layers(i_n_layer, 5'(N_LAYER));
    assign w_src_end    = i_src_valid & i_src_ready & i_src_last;
    assign w_dst_end    = i_dst_valid & i_dst_ready & i_dst_last;
    assign w_last_layer = ({1'b0, r_idx} == (r_n_eff - 5'd1));

    always_comb begin
        w_fetch = w_ram_q;
`ifndef LAYER_SEQ_BIAS_EN
        w_fetch.enbias = 1'b0;
`endif
    end

    // The RAM is read in the cycle that enters FETCH so FETCH can decode the descriptor.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_rd_en     = 1'b0;
        o_wwrite    = 1'b0;
        o_bwrite    = 1'b0;
        o_run       = 1'b0;
        o_busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_idx_nxt = 4'd0;
                    if (w_n_req == 5'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_rd_en     = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (w_fetch.wload)       w_state_nxt = S_WLOAD;
                else if (w_fetch.enbias) w_state_nxt = S_BLOAD;
                else                     w_state_nxt = S_RUN;
            end
            S_WLOAD: begin
                o_wwrite = 1'b1;
                if (w_src_end) begin
                    w_state_nxt = r_desc.enbias ? S_BLOAD : S_RUN;
                end
            end
`ifdef LAYER_SEQ_BIAS_EN
            S_BLOAD: begin
                o_bwrite = 1'b1;
                if (w_src_end) begin
                    w_state_nxt = S_RUN;
                end
            end
`endif
            S_RUN: begin
                o_run = 1'b1;
                if (w_dst_end) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_last_layer) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = S_FETCH;
                    w_rd_en     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = r_idx;
            w_done_nxt  = 1'b0;
            w_rd_en     = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_n_eff <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            if (r_state == S_IDLE && i_start && !i_abort) begin
                r_n_eff <= w_n_req;
            end
        end
    end

    // Geometry is captured at the end of FETCH and held until the next FETCH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_desc <= '0;
        end else if (r_state == S_FETCH && !i_abort) begin
            r_desc <= w_fetch;
        end
    end

    assign o_backprop  = r_desc.backprop;
    assign o_enbias    = r_desc.enbias;
    assign o_ss        = r_desc.ss;
    assign o_dd        = r_desc.dd;
    assign o_id        = r_desc.id;
    assign o_is        = r_desc.is;
    assign o_ih        = r_desc.ih;
    assign o_iw        = r_desc.iw;
    assign o_ds        = r_desc.ds;
    assign o_od        = r_desc.od;
    assign o_os        = r_desc.os;
    assign o_oh        = r_desc.oh;
    assign o_ow        = r_desc.ow;
    assign o_fs        = r_desc.fs;
    assign o_ks        = r_desc.ks;
    assign o_kh        = r_desc.kh;
    assign o_kw        = r_desc.kw;
    assign o_done      = r_done;
    assign o_layer_idx = r_idx;

endmodule
